// File: rtl/dom_gf_pkg.sv
// Shared GF(2^n) helpers for the DOM-indep multiplier: field multiply, share-pair
// enumeration and configuration legality.
package dom_gf_pkg;

    localparam int MAX_WIDTH = 4;

    // Polynomial-basis multiply; both legal fields reduce x^WIDTH to x+1 (0b0011).
    function automatic logic [MAX_WIDTH-1:0] gf_mul(input logic [MAX_WIDTH-1:0] a,
                                                    input logic [MAX_WIDTH-1:0] b,
                                                    input int width);
        logic [MAX_WIDTH-1:0] acc;
        logic [MAX_WIDTH-1:0] sh;
        logic [MAX_WIDTH-1:0] mask;
        logic                 msb;
        acc  = 4'h0;
        sh   = a;
        mask = (width == 32'sd2) ? 4'h3 : 4'hF;
        for (int k = 0; k < MAX_WIDTH; k++) begin
            acc = acc ^ (((k < width) && b[k]) ? sh : 4'h0);
            msb = (width == 32'sd2) ? sh[1] : sh[3];
            sh  = ((sh << 1) & mask) ^ (msb ? 4'h3 : 4'h0);
        end
        return acc;
    endfunction

    function automatic int n_pairs(input int shares);
        return (shares * (shares - 32'sd1)) / 32'sd2;
    endfunction

    // Lexicographic index of the unordered pair {i,j}, i != j.
    function automatic int pair_idx(input int i, input int j, input int shares);
        int lo;
        int hi;
        int idx;
        lo  = (i < j) ? i : j;
        hi  = (i < j) ? j : i;
        idx = 32'sd0;
        for (int k = 0; k < lo; k++) begin
            idx = idx + shares - 32'sd1 - k;
        end
        return idx + hi - lo - 32'sd1;
    endfunction

    function automatic bit legal_config(input int shares, input int width, input int lanes);
        return (shares >= 32'sd2) && ((width == 32'sd2) || (width == 32'sd4)) && (lanes >= 32'sd1);
    endfunction

endpackage

// File: rtl/dom_gf2n_lane.sv
// One lane of the DOM-indep multiplier: stage-1 inner/cross-term registers and
// the share-wise compression that reads only those registers.
module dom_gf2n_lane
    import dom_gf_pkg::*;
#(
    parameter int SHARES = 2,
    parameter int WIDTH  = 2
) (
    input  logic                               ClkxCI,
    input  logic                               RstxBI,
    input  logic                               Load1xS,
    input  logic [SHARES*WIDTH-1:0]            XxDI,
    input  logic [SHARES*WIDTH-1:0]            YxDI,
    input  logic [n_pairs(SHARES)*WIDTH-1:0]   ZxDI,
    output logic [SHARES*WIDTH-1:0]            QxDO
);

    // Diagonal [i][i] holds the inner term, off-diagonal [i][j] the masked cross term.
    logic [WIDTH-1:0] term_s [SHARES][SHARES];
    (* keep = "true" *) logic [WIDTH-1:0] term_r [SHARES][SHARES];
    logic [SHARES*WIDTH-1:0] q_s;

    for (genvar gI = 0; gI < SHARES; gI++) begin : gRow
        for (genvar gJ = 0; gJ < SHARES; gJ++) begin : gCol
            if (gI == gJ) begin : gInner
                assign term_s[gI][gJ] = WIDTH'(gf_mul(4'(XxDI[gI*WIDTH +: WIDTH]),
                                                      4'(YxDI[gJ*WIDTH +: WIDTH]), WIDTH));
            end else begin : gCross
                localparam int PIDX = pair_idx(gI, gJ, SHARES);
                assign term_s[gI][gJ] = WIDTH'(gf_mul(4'(XxDI[gI*WIDTH +: WIDTH]),
                                                      4'(YxDI[gJ*WIDTH +: WIDTH]), WIDTH))
                                        ^ ZxDI[PIDX*WIDTH +: WIDTH];
            end
        end
    end

    // Stage-1 term registers; hold contents (valid or not) when not loading.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            term_r <= '{default: '0};
        end else if (Load1xS) begin
            term_r <= term_s;
        end else begin
            term_r <= term_r;
        end
    end

    // Compression: each output share folds only its own registered row.
    always_comb begin
        q_s = '0;
        for (int i = 0; i < SHARES; i++) begin
            for (int j = 0; j < SHARES; j++) begin
                q_s[i*WIDTH +: WIDTH] = q_s[i*WIDTH +: WIDTH] ^ term_r[i][j];
            end
        end
    end

    assign QxDO = q_s;

endmodule

// File: rtl/dom_shared_mul_gf2n_lanes.sv
// LANES parallel DOM-indep GF(2^WIDTH) multipliers sharing one masked Y operand,
// behind an elastic valid/ready pipeline of one or two stages.
module dom_shared_mul_gf2n_lanes
    import dom_gf_pkg::*;
#(
    parameter int SHARES    = 2,
    parameter int WIDTH     = 2,
    parameter int LANES     = 4,
    parameter int PIPELINED = 1
) (
    input  logic                                     ClkxCI,
    input  logic                                     RstxBI,
    input  logic                                     InValidxSI,
    output logic                                     InReadyxSO,
    input  logic [LANES*SHARES*WIDTH-1:0]            XxDI,
    input  logic [SHARES*WIDTH-1:0]                  YxDI,
    input  logic [LANES*n_pairs(SHARES)*WIDTH-1:0]   ZxDI,
    output logic                                     RndAckxSO,
    output logic                                     OutValidxSO,
    input  logic                                     OutReadyxSI,
    output logic [LANES*SHARES*WIDTH-1:0]            QxDO
);

    localparam int SW = SHARES * WIDTH;
    localparam int PW = n_pairs(SHARES) * WIDTH;

    if (!legal_config(SHARES, WIDTH, LANES)) begin : gIllegal
        $error("dom_shared_mul_gf2n_lanes: need SHARES>=2, WIDTH in {2,4}, LANES>=1");
    end

    logic                  valid1_r;
    logic                  ready1_s;
    logic [LANES*SW-1:0]   comp_s;

    assign InReadyxSO = ready1_s;
    assign RndAckxSO  = InValidxSI & ready1_s;

    // Stage-1 valid bit, common to all lanes.
    always_ff @(posedge ClkxCI or negedge RstxBI) begin
        if (!RstxBI) begin
            valid1_r <= 1'b0;
        end else if (ready1_s) begin
            valid1_r <= InValidxSI;
        end else begin
            valid1_r <= valid1_r;
        end
    end

    for (genvar gL = 0; gL < LANES; gL++) begin : gLane
        dom_gf2n_lane #(
            .SHARES (SHARES),
            .WIDTH  (WIDTH)
        ) uLane (
            .ClkxCI  (ClkxCI),
            .RstxBI  (RstxBI),
            .Load1xS (ready1_s),
            .XxDI    (XxDI[gL*SW +: SW]),
            .YxDI    (YxDI),
            .ZxDI    (ZxDI[gL*PW +: PW]),
            .QxDO    (comp_s[gL*SW +: SW])
        );
    end

    if (PIPELINED != 0) begin : gPipe
        logic                valid2_r;
        logic                ready2_s;
        logic [LANES*SW-1:0] q2_r;

        assign ready2_s = ~valid2_r | OutReadyxSI;
        assign ready1_s = ~valid1_r | ready2_s;

        // Output stage: registered compression result and its valid bit.
        always_ff @(posedge ClkxCI or negedge RstxBI) begin
            if (!RstxBI) begin
                valid2_r <= 1'b0;
                q2_r     <= '0;
            end else if (ready2_s) begin
                valid2_r <= valid1_r;
                q2_r     <= comp_s;
            end else begin
                valid2_r <= valid2_r;
                q2_r     <= q2_r;
            end
        end

        assign OutValidxSO = valid2_r;
        assign QxDO        = q2_r;
    end else begin : gDirect
        assign ready1_s    = ~valid1_r | OutReadyxSI;
        assign OutValidxSO = valid1_r;
        assign QxDO        = comp_s;
    end

endmodule

// File: tb/tb_dom_shared_mul_gf2n_lanes.sv
// Self-checking bench: a 3-share GF(16) 4-lane pipelined instance driven against a
// scoreboard, plus a 2-share GF(4) single-lane unpipelined instance.
module tb_dom_shared_mul_gf2n_lanes;

    logic clk;
    logic rstn;

    logic        inValidA, inReadyA, rndAckA, outValidA, outReadyA;
    logic [47:0] xA;
    logic [11:0] yA;
    logic [47:0] zA;
    logic [47:0] qA;

    logic        inValidB, inReadyB, rndAckB, outValidB, outReadyB;
    logic [3:0]  xB;
    logic [3:0]  yB;
    logic [1:0]  zB;
    logic [3:0]  qB;

    dom_shared_mul_gf2n_lanes #(.SHARES(3), .WIDTH(4), .LANES(4), .PIPELINED(1)) uDutA (
        .ClkxCI(clk), .RstxBI(rstn), .InValidxSI(inValidA), .InReadyxSO(inReadyA),
        .XxDI(xA), .YxDI(yA), .ZxDI(zA), .RndAckxSO(rndAckA),
        .OutValidxSO(outValidA), .OutReadyxSI(outReadyA), .QxDO(qA)
    );

    dom_shared_mul_gf2n_lanes #(.SHARES(2), .WIDTH(2), .LANES(1), .PIPELINED(0)) uDutB (
        .ClkxCI(clk), .RstxBI(rstn), .InValidxSI(inValidB), .InReadyxSO(inReadyB),
        .XxDI(xB), .YxDI(yB), .ZxDI(zB), .RndAckxSO(rndAckB),
        .OutValidxSO(outValidB), .OutReadyxSI(outReadyB), .QxDO(qB)
    );

    typedef struct {
        logic [3:0] x;
        logic [3:0] y;
        logic [3:0] q;
    } vec_t;

    int          nVec = 0;
    int          nFail = 0;
    logic [15:0] sbA[$];
    logic [15:0] curExpA;
    logic        accA, delA, lastOV, stallPrev;
    logic [47:0] prevQ;
    int          ackCnt, delCnt;
    int          hist[16];
    logic        histOn;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL timeout: simulation exceeded its time budget");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Carry-less product followed by long division by the field polynomial.
    function automatic logic [3:0] refMul(input logic [3:0] a, input logic [3:0] b, input int w);
        logic [7:0] p;
        logic [7:0] poly;
        p    = 8'h00;
        poly = (w == 2) ? 8'h07 : 8'h13;
        for (int k = 0; k < w; k++) if (b[k]) p = p ^ (8'(a) << k);
        for (int k = 2 * w - 2; k >= w; k--) if (p[k]) p = p ^ (poly << (k - w));
        return p[3:0];
    endfunction

    function automatic logic [15:0] unmaskA(input logic [47:0] q);
        logic [15:0] r;
        r = 16'h0000;
        for (int l = 0; l < 4; l++)
            for (int s = 0; s < 3; s++)
                r[l*4 +: 4] = r[l*4 +: 4] ^ q[(l*3+s)*4 +: 4];
        return r;
    endfunction

    task automatic genBeatA(input logic [15:0] xv, input logic [3:0] yv, input logic [15:0] ev);
        logic [3:0] s0, s1;
        for (int l = 0; l < 4; l++) begin
            s0 = 4'($urandom());
            s1 = 4'($urandom());
            xA[(l*3+0)*4 +: 4] = s0;
            xA[(l*3+1)*4 +: 4] = s1;
            xA[(l*3+2)*4 +: 4] = xv[l*4 +: 4] ^ s0 ^ s1;
        end
        s0 = 4'($urandom());
        s1 = 4'($urandom());
        yA = {yv ^ s0 ^ s1, s1, s0};
        zA = 48'({$urandom(), $urandom()});
        curExpA = ev;
    endtask

    task automatic genRandomA();
        logic [15:0] xv, ev;
        logic [3:0]  yv;
        xv = 16'($urandom());
        yv = 4'($urandom());
        for (int l = 0; l < 4; l++) ev[l*4 +: 4] = refMul(xv[l*4 +: 4], yv, 4);
        genBeatA(xv, yv, ev);
    endtask

    // One cycle of DUT A: sample at negedge+1, score, then advance to the next negedge.
    task automatic stepA();
        logic expRdy;
        logic [15:0] e;
        #1;
        expRdy = (sbA.size() < 2) || outReadyA;
        chk("a_inready", 48'(inReadyA), 48'(expRdy));
        accA   = inValidA && inReadyA;
        delA   = outValidA && outReadyA;
        lastOV = outValidA;
        chk("a_rndack", 48'(rndAckA), 48'(accA));
        if (rndAckA) ackCnt++;
        if (stallPrev) chk("a_stable", qA, prevQ);
        if (delA) begin
            if (sbA.size() == 0) begin
                nVec++;
                nFail++;
                $display("FAIL a_spurious: output %0h delivered with nothing in flight", qA);
            end else begin
                e = sbA.pop_front();
                chk("a_result", 48'(unmaskA(qA)), 48'(e));
                delCnt++;
                if (histOn) hist[qA[3:0]]++;
            end
        end
        stallPrev = outValidA && !outReadyA;
        prevQ     = qA;
        if (accA) sbA.push_back(curExpA);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic driveB(input logic [1:0] x, input logic [1:0] y);
        logic [1:0] s;
        s  = 2'($urandom());
        xB = {x ^ s, s};
        s  = 2'($urandom());
        yB = {y ^ s, s};
        zB = 2'($urandom());
    endtask

    initial begin
        vec_t        tbl[7];
        logic [3:0]  expPrev;
        logic [3:0]  qHold;
        logic [1:0]  bx, by;
        logic [15:0] xv, ev;
        int          accStall, delBefore;

        tbl[0] = '{x: 4'h2, y: 4'h8, q: 4'h3};
        tbl[1] = '{x: 4'hF, y: 4'hF, q: 4'hA};
        tbl[2] = '{x: 4'h1, y: 4'h7, q: 4'h7};
        tbl[3] = '{x: 4'h0, y: 4'h5, q: 4'h0};
        tbl[4] = '{x: 4'h3, y: 4'h3, q: 4'h5};
        tbl[5] = '{x: 4'h4, y: 4'h4, q: 4'h3};
        tbl[6] = '{x: 4'h9, y: 4'h2, q: 4'h1};

        rstn = 1'b0;
        inValidA = 1'b0; outReadyA = 1'b1; xA = '0; yA = '0; zA = '0;
        inValidB = 1'b0; outReadyB = 1'b1; xB = '0; yB = '0; zB = '0;
        stallPrev = 1'b0; ackCnt = 0; delCnt = 0; histOn = 1'b0; curExpA = '0;
        for (int b = 0; b < 16; b++) hist[b] = 0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_outvalid_a", 48'(outValidA), 48'(0));
        chk("rst_q_a", qA, 48'(0));
        chk("rst_outvalid_b", 48'(outValidB), 48'(0));
        chk("rst_q_b", 48'(qB), 48'(0));
        @(negedge clk);
        rstn = 1'b1;
        #1;
        chk("rst_inready_a", 48'(inReadyA), 48'(1));
        chk("rst_inready_b", 48'(inReadyB), 48'(1));
        @(negedge clk);

        // Single beat latency on the pipelined instance.
        genBeatA({4{4'h2}}, 4'h8, {4{4'h3}});
        inValidA = 1'b1;
        ackCnt = 0;
        stepA();
        inValidA = 1'b0;
        stepA();
        chk("lat_cycle1", 48'(lastOV), 48'(0));
        stepA();
        chk("lat_cycle2", 48'(lastOV), 48'(1));
        stepA();
        chk("lat_after", 48'(lastOV), 48'(0));
        chk("ack_once", 48'(ackCnt), 48'(1));

        // Hand-derived GF(16) vectors, back to back.
        for (int t = 0; t < 7; t++) begin
            genBeatA({4{tbl[t].x}}, tbl[t].y, {4{tbl[t].q}});
            inValidA = 1'b1;
            stepA();
        end
        inValidA = 1'b0;
        repeat (3) stepA();

        // Full GF(16) operand sweep: four x values per beat across the lanes.
        for (int y = 0; y < 16; y++) begin
            for (int g = 0; g < 4; g++) begin
                for (int l = 0; l < 4; l++) begin
                    xv[l*4 +: 4] = 4'(g * 4 + l);
                    ev[l*4 +: 4] = refMul(4'(g * 4 + l), 4'(y), 4);
                end
                genBeatA(xv, 4'(y), ev);
                inValidA = 1'b1;
                stepA();
            end
        end
        inValidA = 1'b0;
        repeat (3) stepA();

        // Throughput and share uniformity over 1000 random beats.
        histOn = 1'b1;
        delBefore = delCnt;
        for (int n = 0; n < 1000; n++) begin
            genRandomA();
            inValidA = 1'b1;
            stepA();
            chk("thru_accept", 48'(accA), 48'(1));
            if (n >= 2) chk("thru_deliver", 48'(delA), 48'(1));
        end
        inValidA = 1'b0;
        repeat (3) stepA();
        histOn = 1'b0;
        chk("thru_count", 48'(delCnt - delBefore), 48'(1000));
        for (int b = 0; b < 16; b++) chk("share_uniform", 48'(hist[b] >= 25), 48'(1));

        // Backpressure: five stalled cycles with a continuous input stream.
        outReadyA = 1'b0;
        accStall = 0;
        genRandomA();
        inValidA = 1'b1;
        repeat (5) begin
            stepA();
            if (accA) begin
                accStall++;
                genRandomA();
            end
        end
        chk("bp_accepted", 48'(accStall), 48'(2));
        outReadyA = 1'b1;
        repeat (6) begin
            stepA();
            if (accA) genRandomA();
        end
        inValidA = 1'b0;
        repeat (3) stepA();
        chk("bp_drained", 48'(sbA.size()), 48'(0));

        // Random valid and ready patterns.
        genRandomA();
        for (int n = 0; n < 300; n++) begin
            inValidA  = ($urandom_range(3) != 0);
            outReadyA = ($urandom_range(2) != 0);
            stepA();
            if (accA) genRandomA();
        end
        inValidA = 1'b0;
        outReadyA = 1'b1;
        repeat (3) stepA();
        chk("rand_drained", 48'(sbA.size()), 48'(0));

        // Asynchronous reset with both stages full.
        outReadyA = 1'b0;
        genRandomA();
        inValidA = 1'b1;
        repeat (3) begin
            stepA();
            if (accA) genRandomA();
        end
        inValidA = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("arst_outvalid", 48'(outValidA), 48'(0));
        chk("arst_q", qA, 48'(0));
        sbA.delete();
        stallPrev = 1'b0;
        @(negedge clk);
        #2 rstn = 1'b1;
        @(negedge clk);
        #1;
        chk("arst_inready", 48'(inReadyA), 48'(1));
        @(negedge clk);
        outReadyA = 1'b1;
        genRandomA();
        inValidA = 1'b1;
        stepA();
        inValidA = 1'b0;
        repeat (3) stepA();
        chk("arst_drained", 48'(sbA.size()), 48'(0));

        // GF(4), two shares, latency 1: fixed-share vector with exact output shares.
        xB = 4'b0010; yB = 4'b0010; zB = 2'b01;
        inValidB = 1'b1;
        #1;
        chk("b_rndack", 48'(rndAckB), 48'(1));
        @(posedge clk);
        @(negedge clk);
        inValidB = 1'b0;
        #1;
        chk("b_outvalid", 48'(outValidB), 48'(1));
        chk("b_shares", 48'(qB), 48'(4'b0110));
        chk("b_rndack_low", 48'(rndAckB), 48'(0));
        @(posedge clk);
        @(negedge clk);
        #1;
        chk("b_outvalid_after", 48'(outValidB), 48'(0));
        @(negedge clk);

        // GF(4) sweep, one beat per cycle, each result checked one cycle later.
        expPrev = 4'h0;
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                bx = 2'(k / 4);
                by = 2'(k % 4);
                driveB(bx, by);
                inValidB = 1'b1;
            end else begin
                inValidB = 1'b0;
            end
            #1;
            if (k > 0) begin
                chk("b_sweep_valid", 48'(outValidB), 48'(1));
                chk("b_sweep", 48'(qB[1:0] ^ qB[3:2]), 48'(expPrev));
            end
            if (k < 16) expPrev = refMul(4'(bx), 4'(by), 2);
            @(posedge clk);
            @(negedge clk);
        end

        // GF(4) backpressure: a single stage stalls after one accepted beat.
        outReadyB = 1'b0;
        driveB(2'd3, 2'd2);
        inValidB = 1'b1;
        #1;
        chk("b_bp_first", 48'(inReadyB), 48'(1));
        @(posedge clk);
        @(negedge clk);
        driveB(2'd2, 2'd2);
        #1;
        qHold = qB;
        repeat (3) begin
            chk("b_bp_inready", 48'(inReadyB), 48'(0));
            chk("b_bp_stable", 48'(qB), 48'(qHold));
            chk("b_bp_ack", 48'(rndAckB), 48'(0));
            @(posedge clk);
            @(negedge clk);
            #1;
        end
        outReadyB = 1'b1;
        #1;
        chk("b_bp_release", 48'(inReadyB), 48'(1));
        chk("b_bp_out1", 48'(qB[1:0] ^ qB[3:2]), 48'(1));
        @(posedge clk);
        @(negedge clk);
        inValidB = 1'b0;
        #1;
        chk("b_bp_out2_valid", 48'(outValidB), 48'(1));
        chk("b_bp_out2", 48'(qB[1:0] ^ qB[3:2]), 48'(3));
        @(posedge clk);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/dom_shared_mul_gf2n_lanes.md
Name: dom_shared_mul_gf2n_lanes

Overview:
- Parametrised domain-oriented-masking (DOM-indep) shared multiplier over GF(2^WIDTH), applied to LANES parallel lanes.
- All lanes share one masked Y operand; each lane has its own masked X operand and fresh Z randomness.
- Successor to the fixed GF(2^2) quadruple multiplier: adds configurable field width, lane count and share count, plus an elastic valid/ready pipeline with stall support.
- Used in the masked S-box datapath wherever several shared GF products use a common factor.

Parameters:
- SHARES, 2, number of shares d+1; must be >= 2.
- WIDTH, 2, field bits; only 2 (GF(4), poly x^2+x+1) or 4 (GF(16), poly x^4+x+1) are legal; any other value is an elaboration error.
- LANES, 4, number of parallel products sharing Y; must be >= 1.
- PIPELINED, 1, 1 = extra output register stage (latency 2); 0 = latency 1.

Ports:
- ClkxCI  in  1  clock, rising edge.
- RstxBI  in  1  reset, asynchronous, active-low.
- InValidxSI  in  1  input operands valid.
- InReadyxSO  out  1  block accepts input this cycle.
- XxDI  in  LANES*SHARES*WIDTH  lane l share s at bits [(l*SHARES+s)*WIDTH +: WIDTH].
- YxDI  in  SHARES*WIDTH  share s at [s*WIDTH +: WIDTH], common to all lanes.
- ZxDI  in  LANES*PAIRS*WIDTH  fresh randomness; PAIRS = SHARES*(SHARES-1)/2; lane l pair p at [(l*PAIRS+p)*WIDTH +: WIDTH]; pairs ordered (0,1),(0,2)..(1,2).. lexicographic, i<j.
- RndAckxSO  out  1  high exactly when InValidxSI && InReadyxSO; Z consumed, source must advance.
- OutValidxSO  out  1  output shares valid.
- OutReadyxSI  in  1  downstream accepts output.
- QxDO  out  LANES*SHARES*WIDTH  product shares, same packing as XxDI.

Behaviour:
- Arithmetic per lane l, share i: inner term I_i = x_i*y_i; cross term C_ij = x_i*y_j XOR z_p(i,j) for every j != i. The same z_p is used for (i,j) and (j,i). All products are polynomial-basis GF(2^WIDTH) multiplications.
- Stage 1 (register S1):
  - Captures every C_ij separately (never pre-XORed before the register) and I_i.
  - Each C_ij is computed purely combinationally from inputs and captured directly, so no cross-domain XOR happens before the register.
  - Carries valid bit V1.
- Compression: Q_i = I_i XOR (XOR over j!=i of registered C_ij), computed from S1 only.
- PIPELINED=0: QxDO is the compression of S1; OutValidxSO = V1.
- PIPELINED=1: the compression result is captured into register S2 with valid bit V2; QxDO = S2; OutValidxSO = V2.
- Handshake (elastic, no bubbles, throughput 1 per cycle):
  - PIPELINED=1: Rdy2 = !V2 || OutReadyxSI; Rdy1 = !V1 || Rdy2; InReadyxSO = Rdy1.
  - PIPELINED=0: InReadyxSO = !V1 || OutReadyxSI.
  - A stage loads only when its ready term is high; otherwise it holds its data and valid bit unchanged.
  - When a stage loads, its valid bit becomes the upstream valid (InValidxSI for S1, V1 for S2).
  - A stage whose data is not loaded keeps its previous contents, even when invalid. This avoids extra toggling of mask-dependent registers.
- Output stability: QxDO is stable while OutValidxSO && !OutReadyxSI.
- No combinational path from XxDI, YxDI or ZxDI to QxDO.
- InReadyxSO depends only on registers and OutReadyxSI.
- Reset: asynchronous assertion clears S1, S2, V1 and V2 to 0, so OutValidxSO=0 and QxDO=0. InReadyxSO=1 once reset is released.
- Reset mid-operation: in-flight data is discarded, not replayed.
- Simultaneous load and drain of a full pipeline in the same cycle is legal and loses no data.
- With InValidxSI=0 the stages still load (fresh-Z-free garbage) when ready, but the valid bits stay 0 and RndAckxSO=0.
- Security requirements:
  - Each share domain's logic uses only share i of X and share i or j of Y.
  - Synthesis keep constraints go on the S1 cross-term registers.

Decomposition:
- Package dom_gf_pkg:
  - function gf_mul(a,b,width) covering polys 0x7 and 0x13;
  - function n_pairs(shares);
  - function pair_idx(i,j,shares);
  - localparam legality checks.
- Sub-module dom_gf2n_lane:
  - one lane's S1 cross and inner registers plus compression;
  - shares the stage load-enables from the top.
- The top holds the valid and ready control and, for PIPELINED=1, the S2 register. The control is common to all lanes.

Test Plan:
- SHARES=2, WIDTH=2, LANES=1, X=(2,0), Y=(2,0), Z=1, single beat, OutReady=1 -> OutValid high 2 cycles after acceptance (1 if PIPELINED=0); Q0^Q1=3; RndAck pulses once.
- WIDTH=4: X shares XOR to 2, Y shares XOR to 8, random shares and Z -> unmasked Q = 3. Second beat, X=0xF, Y=0xF -> Q=0xA. Also sweep all 256 operand pairs against the gf_mul model.
- LANES=4, SHARES=3, 1000 random back-to-back beats with OutReady=1 -> one result per cycle after fill; every unmasked lane equals the model; the Q_i distribution per share is uniform.
- Backpressure: hold OutReady=0 for 5 cycles with a continuous input stream -> InReady drops after 2 accepted beats (1 if PIPELINED=0); QxDO is stable; on release there is no loss or duplication and order is preserved.
- Reset asserted while V1=V2=1 -> OutValid=0 and QxDO=0 immediately (asynchronous); after release, InReady=1 and the first new beat produces a correct result.
- Elaboration with WIDTH=3 or SHARES=1 -> elaboration error.
